param_multi_module: RTL and testbench

Parametrised sequential shift-add multiplier for the Computation datapath. It is the multi-cycle, width-generic successor to the fixed 8-bit array multiplier. It returns the full 2×WIDTH-bit product rather than a truncated WIDTH-bit result, and supports a per-operation unsigned or signed (two's complement) mode. A valid/ready handshake on both input and output lets it sit between register stages of the LCD computation pipeline without combinational array depth.

---
 rtl/param_multi_module.sv | 131 +++++++++++++
 tb/tb_param_multi_module.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/param_multi_module.sv
`default_nettype none
// ============================================================================
// Module   : param_multi_module
// Function : WIDTH-generic sequential shift-add multiplier with full-width
//            product, unsigned/signed mode and valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module param_multi_module #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_sgn;
    logic [CW-1:0]      r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [PW-1:0]      r_out;
    logic               r_ovf;

    logic               w_last;
    logic               w_sub;
    logic [PW-1:0]      w_pp;
    logic [PW-1:0]      w_acc_nxt;
    logic [WIDTH:0]     w_top_s;
    logic               w_ovf_u;
    logic               w_ovf_s;
    logic               w_ovf;
    logic [PW-1:0]      w_mcand_ld;

    // Signed mode: the multiplier MSB carries weight -2^(WIDTH-1), so the
    // final partial product is subtracted rather than added. With a
    // sign-extended multiplicand this yields the exact product mod 2^(2W).
    always_comb begin
        w_last     = (r_cnt == C_CNT_ONE);
        w_sub      = r_sgn & w_last;
        w_pp       = r_mplier[0] ? r_mcand : '0;
        w_acc_nxt  = w_sub ? (r_acc - w_pp) : (r_acc + w_pp);
        w_ovf_u    = |w_acc_nxt[PW-1:WIDTH];
        w_top_s    = w_acc_nxt[PW-1:WIDTH-1];
        w_ovf_s    = (|w_top_s) & ~(&w_top_s);
        w_ovf      = r_sgn ? w_ovf_s : w_ovf_u;
        w_mcand_ld = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a}
                                 : {{WIDTH{1'b0}}, a};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_sgn       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mcand    <= w_mcand_ld;
                        r_mplier   <= b;
                        r_sgn      <= signed_mode;
                        r_acc      <= '0;
                        r_cnt      <= C_CNT_LOAD;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - C_CNT_ONE;
                    if (w_last) begin
                        r_out       <= w_acc_nxt;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_param_multi_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_multi_module
// Function : Self-checking bench for param_multi_module at WIDTH=8 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_multi_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv8, sm8, or8, ir8, ov8, ovf8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;
    logic        iv16, sm16, or16, ir16, ov16, ovf16;
    logic [15:0] a16, b16;
    logic [31:0] out16;

    int tests = 0;
    int fails = 0;
    bit tie_rdy = 1'b0;

    always #5 clk = ~clk;

    param_multi_module #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8),
        .out_ready(or8), .out(out8), .out_ovf(ovf8)
    );

    param_multi_module #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .signed_mode(sm16), .out_valid(ov16),
        .out_ready(or16), .out(out16), .out_ovf(ovf16)
    );

    // Reference: exact integer product of the operands as interpreted by mode
    function automatic longint ref_val(int w, logic [31:0] x, logic [31:0] y, bit s);
        longint m, sx, sy;
        m  = (longint'(1) << w) - 1;
        sx = longint'(x) & m;
        sy = longint'(y) & m;
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        return sx * sy;
    endfunction

    function automatic logic [63:0] ref_prod(int w, logic [31:0] x, logic [31:0] y, bit s);
        return 64'(ref_val(w, x, y, s)) & ((64'(1) << (2 * w)) - 64'(1));
    endfunction

    function automatic logic ref_ovf(int w, logic [31:0] x, logic [31:0] y, bit s);
        longint p;
        p = ref_val(w, x, y, s);
        if (s) return (p < -(longint'(1) << (w - 1))) || (p > ((longint'(1) << (w - 1)) - 1));
        return p > ((longint'(1) << w) - 1);
    endfunction

    function automatic logic [63:0] cur_out(int w);
        return (w == 8) ? 64'(out8) : 64'(out16);
    endfunction
    function automatic logic cur_valid(int w);
        return (w == 8) ? ov8 : ov16;
    endfunction
    function automatic logic cur_ready(int w);
        return (w == 8) ? ir8 : ir16;
    endfunction
    function automatic logic cur_ovf(int w);
        return (w == 8) ? ovf8 : ovf16;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int w, logic v, logic [31:0] x, logic [31:0] y, logic s);
        if (w == 8) begin
            iv8 = v; a8 = x[7:0]; b8 = y[7:0]; sm8 = s;
        end else begin
            iv16 = v; a16 = x[15:0]; b16 = y[15:0]; sm16 = s;
        end
    endtask

    task automatic set_ordy(int w, logic r);
        if (w == 8) or8 = r;
        else        or16 = r;
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge
    // with the DUT idle again, so consecutive calls issue every WIDTH+2 cycles.
    task automatic op(int w, logic [31:0] x, logic [31:0] y, bit s, int bp);
        logic [63:0] ep;
        logic        eo;
        ep = ref_prod(w, x, y, s);
        eo = ref_ovf(w, x, y, s);
        chk("in_ready_idle", 64'(cur_ready(w)), 64'd1);
        drive(w, 1'b1, x, y, s);
        @(negedge clk);
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
        chk("in_ready_busy", 64'(cur_ready(w)), 64'd0);
        for (int k = 1; k <= w; k++) begin
            @(negedge clk);
            chk("out_valid_latency", 64'(cur_valid(w)), 64'(k == w));
        end
        chk("product", cur_out(w), ep);
        chk("ovf", 64'(cur_ovf(w)), 64'(eo));
        for (int k = 0; k < bp; k++) begin
            drive(w, 1'b1, $urandom, $urandom, 1'($urandom));
            @(negedge clk);
            chk("bp_out_hold", cur_out(w), ep);
            chk("bp_valid_hold", 64'(cur_valid(w)), 64'd1);
            chk("bp_in_ready_low", 64'(cur_ready(w)), 64'd0);
        end
        drive(w, 1'b0, 32'd0, 32'd0, 1'b0);
        set_ordy(w, 1'b1);
        @(negedge clk);
        chk("hs_valid_drop", 64'(cur_valid(w)), 64'd0);
        chk("hs_in_ready", 64'(cur_ready(w)), 64'd1);
        chk("idle_out_hold", cur_out(w), ep);
        set_ordy(w, tie_rdy);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(16, 1'b0, 32'd0, 32'd0, 1'b0);
        or8 = 1'b0;
        or16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid8", 64'(ov8), 64'd0);
        chk("rst_out8", 64'(out8), 64'd0);
        chk("rst_ovf8", 64'(ovf8), 64'd0);
        chk("rst_ready8", 64'(ir8), 64'd1);
        chk("rst_valid16", 64'(ov16), 64'd0);
        chk("rst_out16", 64'(out16), 64'd0);
        rst_n = 1'b1;

        // Unsigned directed case, then the same with output backpressure
        op(8, 32'd200, 32'd150, 1'b0, 0);
        chk("u8_7530", cur_out(8), 64'h7530);
        chk("u8_7530_ovf", 64'(ovf8), 64'd1);
        op(8, 32'd200, 32'd150, 1'b0, 5);

        // Signed directed cases including most-negative squared
        op(8, 32'hFD, 32'h05, 1'b1, 0);
        chk("s8_fff1", cur_out(8), 64'hFFF1);
        chk("s8_fff1_ovf", 64'(ovf8), 64'd0);
        op(8, 32'h80, 32'h80, 1'b1, 0);
        chk("s8_4000", cur_out(8), 64'h4000);
        chk("s8_4000_ovf", 64'(ovf8), 64'd1);

        // Reset during iteration 4 of 12*12
        chk("pre_rst_ready", 64'(ir8), 64'd1);
        drive(8, 1'b1, 32'd12, 32'd12, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", 64'(out8), 64'd0);
        chk("midrst_valid", 64'(ov8), 64'd0);
        chk("midrst_ovf", 64'(ovf8), 64'd0);
        chk("midrst_ready", 64'(ir8), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        op(8, 32'd3, 32'd4, 1'b0, 0);
        chk("post_rst_000c", cur_out(8), 64'h000C);

        // Width generality
        op(16, 32'hFFFF, 32'hFFFF, 1'b0, 0);
        chk("u16_fffe0001", cur_out(16), 64'hFFFE0001);
        chk("u16_ovf", 64'(ovf16), 64'd1);
        op(16, 32'hFFFF, 32'hFFFF, 1'b1, 0);
        chk("s16_00000001", cur_out(16), 64'h00000001);
        chk("s16_ovf", 64'(ovf16), 64'd0);

        // Back-to-back random operations with out_ready tied high
        tie_rdy = 1'b1;
        or8 = 1'b1;
        or16 = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 10; i++) op(8, $urandom, $urandom, m[0], 0);
            for (int i = 0; i < 10; i++) op(16, $urandom, $urandom, m[0], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
